// File: rtl/reg_dump_pkg.sv
// Shared encodings for reg_dump_controller.
// The HDR state exists only when REG_DUMP_HEADER_EN is defined.
package reg_dump_pkg;

  localparam int DEF_NB_DATA   = 32;
  localparam int DEF_NB_BYTE   = 8;
  localparam int BYTES_PER_REG = DEF_NB_DATA / DEF_NB_BYTE;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_HALT = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_HDR       = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    WAIT_HALT = ST_WAIT_HALT,
    LOAD      = ST_LOAD,
    SEND      = ST_SEND,
`ifdef REG_DUMP_HEADER_EN
    HDR       = ST_HDR,
`endif
    DONE      = ST_DONE
  } state_e;

endpackage

// File: rtl/reg_dump_controller_word_serializer.sv
// word_serializer: loads a word and emits it MSB byte first over valid/ready,
// flagging the last byte of the word.
module word_serializer #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NB_DATA-1:0] i_word,
  input  logic               i_ready,
  output logic [NB_BYTE-1:0] o_data,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_fire
);

  localparam int BYTES  = NB_DATA / NB_BYTE;
  localparam int NB_CNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BYTES - 1);

  logic [NB_DATA-1:0] shift_q, shift_d;
  logic [NB_CNT-1:0]  count_q, count_d;
  logic               valid_q, valid_d;

  assign o_data  = shift_q[NB_DATA-1 -: NB_BYTE];
  assign o_valid = valid_q;
  assign o_last  = (count_q == LAST_CNT);
  assign o_fire  = valid_q & i_ready;

  // Next-state: a load restarts the word, an accepted byte advances it.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_word;
      count_d = {NB_CNT{1'b0}};
      valid_d = 1'b1;
    end else if (o_fire) begin
      shift_d = shift_q << NB_BYTE;
      count_d = count_q + NB_CNT'(1);
      valid_d = ~o_last;
    end else begin
      shift_d = shift_q;
      count_d = count_q;
      valid_d = valid_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= {NB_DATA{1'b0}};
      count_q <= {NB_CNT{1'b0}};
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/reg_dump_controller.sv
// reg_dump_controller: walks the register bank while halted and streams every
// word to the debug UART. REG_DUMP_HEADER_EN prepends a single 8'hA5 byte.
module reg_dump_controller
  import reg_dump_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_halted,
  input  logic [NB_DATA-1:0] i_reg_data,
  input  logic               i_tx_ready,
  output logic [NB_REG-1:0]  o_read_reg,
  output logic               o_bus_grant,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  state_e            state_q, state_d, first_st;
  logic [NB_REG-1:0] index_q, index_d;
  logic              grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ser_load, ser_valid, ser_last, ser_fire;
  logic [NB_BYTE-1:0] ser_data;
`ifdef REG_DUMP_HEADER_EN
  logic              hdr_sent_q, hdr_sent_d;
`endif

  word_serializer #(.NB_DATA(NB_DATA), .NB_BYTE(NB_BYTE)) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (ser_load),
    .i_word  (i_reg_data),
    .i_ready (i_tx_ready),
    .o_data  (ser_data),
    .o_valid (ser_valid),
    .o_last  (ser_last),
    .o_fire  (ser_fire)
  );

  // Sequencer next-state; halt is only re-examined at register boundaries.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    ser_load = 1'b0;
`ifdef REG_DUMP_HEADER_EN
    hdr_sent_d = hdr_sent_q;
    first_st   = hdr_sent_q ? LOAD : HDR;
`else
    first_st   = LOAD;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          index_d = {NB_REG{1'b0}};
          state_d = i_halted ? first_st : WAIT_HALT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_HALT: begin
        if (i_halted) state_d = first_st;
        else          state_d = WAIT_HALT;
      end
      LOAD: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_fire && ser_last) begin
          if (index_q == {NB_REG{1'b1}}) begin
            state_d = DONE;
          end else begin
            index_d = index_q + NB_REG'(1);
            state_d = i_halted ? LOAD : WAIT_HALT;
          end
        end else begin
          state_d = SEND;
        end
      end
`ifdef REG_DUMP_HEADER_EN
      HDR: begin
        if (i_tx_ready) begin
          hdr_sent_d = 1'b1;
          state_d    = i_halted ? LOAD : WAIT_HALT;
        end else begin
          state_d = HDR;
        end
      end
`endif
      DONE: begin
`ifdef REG_DUMP_HEADER_EN
        hdr_sent_d = 1'b0;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = (state_d == LOAD) || (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == DONE);
  end

  // FSM and registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      index_q <= {NB_REG{1'b0}};
      grant_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REG_DUMP_HEADER_EN
      hdr_sent_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REG_DUMP_HEADER_EN
      hdr_sent_q <= hdr_sent_d;
`endif
    end
  end

  assign o_read_reg  = index_q;
  assign o_bus_grant = grant_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
`ifdef REG_DUMP_HEADER_EN
  assign o_tx_valid = ser_valid | (state_q == HDR);
  assign o_tx_data  = (state_q == HDR) ? NB_BYTE'(HEADER_BYTE) : ser_data;
`else
  assign o_tx_valid = ser_valid;
  assign o_tx_data  = ser_data;
`endif

endmodule

// File: tb/tb_reg_dump_controller.sv
// Directed bench for reg_dump_controller; handles REG_DUMP_HEADER_EN builds.
module tb_reg_dump_controller;
  import reg_dump_pkg::*;

  localparam int NREG = 32;
`ifdef REG_DUMP_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int N_BYTES = NREG * BYTES_PER_REG + HDR_N;

  logic        clk = 1'b0;
  logic        rst, start, halted, tx_ready;
  logic [31:0] reg_data;
  logic [4:0]  read_reg;
  logic        bus_grant, tx_valid, busy, done;
  logic [7:0]  tx_data;
  logic [31:0] bank [NREG];

  assign reg_data = bank[read_reg];

  reg_dump_controller #(.NB_DATA(32), .NB_REG(5), .NB_BYTE(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_halted(halted),
    .i_reg_data(reg_data), .i_tx_ready(tx_ready), .o_read_reg(read_reg),
    .o_bus_grant(bus_grant), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_edge, done_cnt;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [7:0] bytes_q[$];
  logic       grant_rec[$];
  logic [7:0] exp_bytes[$];
  logic       exp_grant[$];

  typedef struct {
    int halt_delay;
    bit toggle;
    int exp_lat;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Byte-stream monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        bytes_q.push_back(tx_data);
        grant_rec.push_back(bus_grant);
      end
      if (done) begin
        done_cnt++;
        done_edge = cyc;
      end
    end
  end

  task automatic clear_mon();
    bytes_q.delete();
    grant_rec.delete();
    done_edge  = -1;
    done_cnt   = 0;
    prev_stall = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_count"}, bytes_q.size(), N_BYTES);
    for (int i = 0; i < bytes_q.size() && i < N_BYTES; i++) begin
      chk({tag, "_byte"}, {i[15:0], bytes_q[i]}, {i[15:0], exp_bytes[i]});
      chk({tag, "_grant"}, {i[15:0], grant_rec[i]}, {i[15:0], exp_grant[i]});
    end
  endtask

  task automatic wait_bytes(input int n, input string name);
    int budget = 0;
    while (bytes_q.size() < n && budget < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      budget++;
    end
    chk(name, bytes_q.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int budget = 0;
    while (done_edge < 0 && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    chk(name, done_edge >= 0, 1'b1);
  endtask

  task automatic run_dump(input int halt_delay, input bit toggle, output int lat);
    int s_edge;
    int budget = 0;
    clear_mon();
    halted   = (halt_delay == 0);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start  = 1'b1;
    s_edge = cyc + 1;
    for (int i = 0; i < halt_delay; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      chk("wait_halt_grant", {bus_grant, busy}, 2'b01);
    end
    halted = 1'b1;
    while (done_edge < 0 && budget < 3000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (toggle) tx_ready = ~tx_ready;
      budget++;
    end
    chk("done_seen", done_edge >= 0, 1'b1);
    tx_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_after_done", {busy, done, done_cnt == 1}, 3'b001);
    lat = done_edge - s_edge;
  endtask

  initial begin
    int lat;
    logic [31:0] w;
    rst = 1'b1; start = 1'b0; halted = 1'b0; tx_ready = 1'b1;

    vecs[0] = '{halt_delay: 0,  toggle: 1'b0, exp_lat: 161 + HDR_N};
    vecs[1] = '{halt_delay: 10, toggle: 1'b0, exp_lat: 171 + HDR_N};
    vecs[2] = '{halt_delay: 0,  toggle: 1'b1, exp_lat: 257 + 2 * HDR_N};

`ifdef REG_DUMP_HEADER_EN
    exp_bytes.push_back(8'hA5);
    exp_grant.push_back(1'b0);
`endif
    for (int k = 0; k < NREG; k++) begin
      w = (32'h0100_0000 * 32'(k)) + 32'(k);
      bank[k] = w;
      for (int b = 0; b < BYTES_PER_REG; b++) begin
        exp_bytes.push_back(w[31 - 8 * b -: 8]);
        exp_grant.push_back(1'b1);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {read_reg, bus_grant, tx_data, tx_valid, busy, done}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {read_reg, bus_grant, tx_data, tx_valid, busy, done}, 64'd0);

    for (int v = 0; v < 3; v++) begin
      run_dump(vecs[v].halt_delay, vecs[v].toggle, lat);
      check_stream($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_done_latency", v), lat, vecs[v].exp_lat);
    end

    // Halt drops during the second byte of register 3.
    clear_mon();
    halted = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    wait_bytes(13 + HDR_N, "drop_reach");
    halted = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    for (int i = 0; i < 6; i++) begin
      chk("drop_hold", {bus_grant, busy, tx_valid, read_reg}, {3'b010, 5'd4});
      @(posedge clk); #1;
    end
    chk("drop_count", bytes_q.size(), 16 + HDR_N);
    halted = 1'b1;
    wait_done("drop_done");
    check_stream("drop");

    // Reset lands while register 7 is being sent.
    repeat (2) begin @(posedge clk); #1; end
    clear_mon();
    halted = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    wait_bytes(29 + HDR_N, "rst_reach");
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_reset", {read_reg, bus_grant, tx_data, tx_valid, busy, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_dump(0, 1'b0, lat);
    check_stream("post_reset");
    chk("post_reset_latency", lat, 161 + HDR_N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
